// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory-wait watchdog.
// Define SEQ_PERF_COUNTERS_EN to build the retired-instruction and cycle counters.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       type_code,
  input  logic             load,
  input  logic             should_branch_to_link,
  input  logic             set_cond_bit,
  input  logic             write_condition,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             wb_sel_ram,
  output logic             cpsr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic [1:0] op_type;
  logic       op_load;

  assign state = cur;
  assign fault = (cur == S_FAULT);

  always_comb begin
    nxt        = cur;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    wb_sel_ram = 1'b0;
    cpsr_write = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          nxt     = S_DECODE;
        end else if (wait_cnt == TIMEOUT) begin
          nxt = S_FAULT;
        end
      end
      S_DECODE: nxt = S_EXECUTE;
      S_EXECUTE: begin
        cpsr_write = set_cond_bit & write_condition;
        case (type_code)
          2'b00: nxt = S_WRITEBACK;
          2'b01: nxt = S_MEMORY;
          2'b10: begin
            pc_write = 1'b1;
            if (write_condition)
              pc_src = should_branch_to_link ? 2'b10 : 2'b01;
            nxt = S_FETCH;
          end
          default: nxt = S_FAULT;
        endcase
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = op_load & write_condition;
        if (dmem_ready) begin
          if (!op_load) begin
            wb_sel_ram = 1'b1;
            nxt        = S_WRITEBACK;
          end else begin
            pc_write = 1'b1;
            nxt      = S_FETCH;
          end
        end else if (wait_cnt == TIMEOUT) begin
          nxt = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        reg_write  = write_condition;
        wb_sel_ram = (op_type == 2'b01) && !op_load;
        pc_write   = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_FAULT;
    endcase
    // Strobes must drop the instant reset asserts, before the flops settle.
    if (!reset) begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_write  = 1'b0;
      wb_sel_ram = 1'b0;
      cpsr_write = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur      <= S_FETCH;
      wait_cnt <= 8'd0;
      op_type  <= 2'b00;
      op_load  <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= 8'd0;
      else if ((cur == S_FETCH && !imem_ready) || (cur == S_MEMORY && !dmem_ready))
        wait_cnt <= wait_cnt + 8'd1;
      if (cur == S_EXECUTE) begin
        op_type <= type_code;
        op_load <= load;
      end
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic             retire;
  logic [CNT_W-1:0] instr_q, cycle_q;

  // Retire points: taken/untaken branch, completed store, any writeback.
  assign retire = (cur == S_EXECUTE && type_code == 2'b10) ||
                  (cur == S_MEMORY && dmem_ready && op_load) ||
                  (cur == S_WRITEBACK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      if (retire)
        instr_q <= instr_q + CNT_W'(1);
      if (cur != S_FAULT)
        cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign instr_count = instr_q;
  assign cycle_count = cycle_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer plus hand sequences for
// reset abort, illegal opcode and the wait watchdog.
module tb_multicycle_sequencer;

`ifdef SEQ_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [9:0] IMQ = 10'h200, IRL = 10'h100, DMQ = 10'h080, DWE = 10'h040,
                         RGW = 10'h020, WBR = 10'h010, CPW = 10'h008, PCW = 10'h004,
                         PC_LNK = 10'h002, PC_ALU = 10'h001;

  logic        clock, reset;
  logic [1:0]  type_code;
  logic        load, should_branch_to_link, set_cond_bit, write_condition;
  logic        imem_ready, dmem_ready;
  logic        imem_req, ir_load, dmem_req, dmem_we, reg_write, wb_sel_ram;
  logic        cpsr_write, pc_write, fault;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] instr_count, cycle_count;
  logic [9:0]  obs;

  assign obs = {imem_req, ir_load, dmem_req, dmem_we, reg_write, wb_sel_ram,
                cpsr_write, pc_write, pc_src};

  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .type_code(type_code), .load(load),
    .should_branch_to_link(should_branch_to_link), .set_cond_bit(set_cond_bit),
    .write_condition(write_condition), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write(reg_write), .wb_sel_ram(wb_sel_ram), .cpsr_write(cpsr_write),
    .pc_write(pc_write), .pc_src(pc_src), .state(state), .fault(fault),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0] tc;
    logic       ld, sbl, scb, wc, ir, dr;
    logic [2:0] st;
    logic [9:0] o;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void row(input logic [1:0] tc, input logic ld, sbl, scb, wc, ir, dr,
                              input logic [2:0] st, input logic [9:0] o);
    vec_t v;
    v.tc = tc; v.ld = ld; v.sbl = sbl; v.scb = scb; v.wc = wc; v.ir = ir; v.dr = dr;
    v.st = st; v.o = o;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] tc, input logic ld, sbl, scb, wc, ir, dr);
    type_code = tc; load = ld; should_branch_to_link = sbl; set_cond_bit = scb;
    write_condition = wc; imem_ready = ir; dmem_ready = dr;
  endtask

  // Leaves the bench #1 after a posedge with reset released: the start of cycle 1.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  int exp_instr;
  int t;

  initial begin
    // ALU, set flags, condition passes
    row(0,0,0,1,1,1,1, 0, IMQ|IRL); row(0,0,0,1,1,1,1, 1, 0);
    row(0,0,0,1,1,1,1, 2, CPW);     row(0,0,0,1,1,1,1, 4, RGW|PCW);
    // Load, dmem_ready late by 3 cycles; garbage op fields after EXECUTE
    row(1,0,0,0,1,1,1, 0, IMQ|IRL); row(1,0,0,0,1,1,1, 1, 0);
    row(1,0,0,0,1,1,1, 2, 0);
    row(3,1,0,0,1,1,0, 3, DMQ);     row(3,1,0,0,1,1,0, 3, DMQ);
    row(3,1,0,0,1,1,0, 3, DMQ);     row(3,1,0,0,1,1,1, 3, DMQ|WBR);
    row(3,1,0,0,1,1,1, 4, RGW|WBR|PCW);
    // Branch to link, condition passes
    row(2,0,1,0,1,1,1, 0, IMQ|IRL); row(2,0,1,0,1,1,1, 1, 0);
    row(2,0,1,0,1,1,1, 2, PCW|PC_LNK);
    // Same branch, condition fails (flag update also suppressed)
    row(2,0,1,1,0,1,1, 0, IMQ|IRL); row(2,0,1,1,0,1,1, 1, 0);
    row(2,0,1,1,0,1,1, 2, PCW);
    // Branch to ALU target with flag update
    row(2,0,0,1,1,1,1, 0, IMQ|IRL); row(2,0,0,1,1,1,1, 1, 0);
    row(2,0,0,1,1,1,1, 2, CPW|PCW|PC_ALU);
    // Store, condition fails
    row(1,1,0,1,0,1,1, 0, IMQ|IRL); row(1,1,0,1,0,1,1, 1, 0);
    row(1,1,0,1,0,1,1, 2, 0);       row(1,1,0,1,0,1,1, 3, DMQ|PCW);
    // Store, ready arrives exactly when the wait counter reaches the timeout
    row(1,1,0,0,1,1,1, 0, IMQ|IRL); row(1,1,0,0,1,1,1, 1, 0);
    row(1,1,0,0,1,1,1, 2, 0);
    row(1,1,0,0,1,1,0, 3, DMQ|DWE); row(1,1,0,0,1,1,0, 3, DMQ|DWE);
    row(1,1,0,0,1,1,0, 3, DMQ|DWE); row(1,1,0,0,1,1,0, 3, DMQ|DWE);
    row(1,1,0,0,1,1,1, 3, DMQ|DWE|PCW);
    // ALU, condition fails
    row(0,0,0,1,0,1,1, 0, IMQ|IRL); row(0,0,0,1,0,1,1, 1, 0);
    row(0,0,0,1,0,1,1, 2, 0);       row(0,0,0,1,0,1,1, 4, PCW);

    // Reset state: strobes held low even with both readies high
    drive(0,0,0,1,1,1,1);
    reset = 1'b0;
    #1;
    chk("reset strobes", 32'(obs), 32'h0);
    chk("reset state", 32'(state), 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    chk("reset instr_count", instr_count, 32'd0);
    chk("reset cycle_count", cycle_count, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    exp_instr = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].tc, tbl[i].ld, tbl[i].sbl, tbl[i].scb, tbl[i].wc, tbl[i].ir, tbl[i].dr);
      if (tbl[i].o & PCW) exp_instr++;
      @(negedge clock);
      chk($sformatf("row%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("row%0d strobes", i), 32'(obs), 32'(tbl[i].o));
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("after table state", 32'(state), 32'd0);
    chk("instr_count", instr_count, PERF ? 32'(exp_instr) : 32'd0);
    chk("cycle_count", cycle_count, PERF ? 32'(tbl.size()) : 32'd0);

    // Reset asserted mid-MEMORY aborts immediately
    do_reset();
    drive(1,1,0,0,1,1,0);
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    chk("abort pre state", 32'(state), 32'd3);
    chk("abort pre strobes", 32'(obs), 32'(DMQ|DWE));
    reset = 1'b0;
    #1;
    chk("abort strobes", 32'(obs), 32'h0);
    chk("abort state", 32'(state), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("abort restart strobes", 32'(obs), 32'(IMQ|IRL));

    // Illegal type goes to FAULT out of EXECUTE
    do_reset();
    drive(3,0,0,1,1,1,1);
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    chk("illegal state", 32'(state), 32'd5);
    chk("illegal fault", 32'(fault), 32'd1);
    chk("illegal strobes", 32'(obs), 32'h0);
    repeat (3) @(negedge clock);
    chk("illegal held", 32'(state), 32'd5);
    chk("illegal cycle_count", cycle_count, PERF ? 32'd3 : 32'd0);

    // Watchdog: imem_ready held low
    drive(0,0,0,0,1,0,1);
    do_reset();
    t = 0;
    for (int k = 0; k < 8 && state != 3'd5; k++) begin
      @(negedge clock);
      if (state != 3'd5) begin
        t++;
        chk($sformatf("wait%0d strobes", k), 32'(obs), 32'(IMQ));
      end
      @(posedge clock);
      #1;
    end
    chk("timeout fetch cycles", 32'(t), 32'd5);
    @(negedge clock);
    chk("timeout state", 32'(state), 32'd5);
    chk("timeout fault", 32'(fault), 32'd1);
    imem_ready = 1'b1;
    repeat (4) @(negedge clock);
    chk("timeout held", 32'(state), 32'd5);
    chk("timeout held strobes", 32'(obs), 32'h0);
    do_reset();
    @(negedge clock);
    chk("recover state", 32'(state), 32'd0);
    chk("recover fault", 32'(fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
